// File: rtl/alu_cdest_cre_pkg.sv
// Shared constants for the execute-stage ALU and decode helpers.
// Opcode, funct and ALU operation encodings live here.
package alu_cdest_cre_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_LUI  = 4'd11;
    localparam logic [3:0] OP_EQ   = 4'd12;
    localparam logic [3:0] OP_NE   = 4'd13;
    localparam logic [3:0] OP_PASSB = 4'd14;
    localparam logic [3:0] OP_PASSA = 4'd15;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_XORI  = 6'h0E;
    localparam logic [5:0] OPC_LUI   = 6'h0F;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_JR  = 6'h08;

    localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/alu_cdest_cre_if.sv
// Operand/instruction inputs and registered result/decode outputs.
// master drives operands, slave is the execute block.
interface alu_cdest_cre_if;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_op;
    logic [31:0] dest_instr;
    logic [31:0] src_instr;
    logic [31:0] result;
    logic        zero;
    logic        lt;
    logic        gt;
    logic        bcond;
    logic [4:0]  ws;
    logic        we;
    logic        re1;

    modport master (
        output a, b, alu_op, dest_instr, src_instr,
        input  result, zero, lt, gt, bcond, ws, we, re1
    );

    modport slave (
        input  a, b, alu_op, dest_instr, src_instr,
        output result, zero, lt, gt, bcond, ws, we, re1
    );
endinterface

// File: rtl/alu_cdest_cre_alu_core.sv
// Combinational 32-bit ALU with signed compare and branch flags.
module alu_cdest_cre_alu_core
    import alu_cdest_cre_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [3:0]  alu_op_i,
    output logic [31:0] result_o,
    output logic        zero_o,
    output logic        lt_o,
    output logic        gt_o,
    output logic        bcond_o
);

    logic [31:0] diff;
    logic [4:0]  shamt;

    assign diff  = a_i - b_i;
    assign shamt = a_i[4:0];
    // Flags compare the operands, not the result
    assign lt_o   = $signed(a_i) < $signed(b_i);
    assign gt_o   = $signed(a_i) > $signed(b_i);
    assign zero_o = (result_o == 32'd0);

    always_comb begin
        result_o = 32'd0;
        bcond_o  = 1'b0;
        unique case (alu_op_i)
            OP_ADD:   result_o = a_i + b_i;
            OP_SUB:   result_o = diff;
            OP_AND:   result_o = a_i & b_i;
            OP_OR:    result_o = a_i | b_i;
            OP_XOR:   result_o = a_i ^ b_i;
            OP_NOR:   result_o = ~(a_i | b_i);
            OP_SLT:   result_o = {31'd0, lt_o};
            OP_SLTU:  result_o = {31'd0, a_i < b_i};
            OP_SLL:   result_o = b_i << shamt;
            OP_SRL:   result_o = b_i >> shamt;
            OP_SRA:   result_o = 32'($signed(b_i) >>> shamt);
            OP_LUI:   result_o = {b_i[15:0], 16'h0000};
            OP_EQ: begin
                result_o = diff;
                bcond_o  = (a_i == b_i);
            end
            OP_NE: begin
                result_o = diff;
                bcond_o  = (a_i != b_i);
            end
            OP_PASSB: result_o = b_i;
            OP_PASSA: result_o = a_i;
        endcase
    end

endmodule

// File: rtl/alu_cdest_cre.sv
// Execute-stage ALU plus destination/rs-usage decode, all outputs
// registered at the ID/EX to EX/MEM boundary.
module alu_cdest_cre
    import alu_cdest_cre_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    alu_cdest_cre_if.slave io
);

    logic [31:0] result_d, result_q;
    logic        zero_d, zero_q;
    logic        lt_d, lt_q;
    logic        gt_d, gt_q;
    logic        bcond_d, bcond_q;
    logic [4:0]  ws_d, ws_q;
    logic        we_d, we_q;
    logic        re1_d, re1_q;

    logic [5:0]  d_opc, d_fn, s_opc, s_fn;

    alu_cdest_cre_alu_core u_alu (
        .a_i      (io.a),
        .b_i      (io.b),
        .alu_op_i (io.alu_op),
        .result_o (result_d),
        .zero_o   (zero_d),
        .lt_o     (lt_d),
        .gt_o     (gt_d),
        .bcond_o  (bcond_d)
    );

    assign d_opc = io.dest_instr[31:26];
    assign d_fn  = io.dest_instr[5:0];
    assign s_opc = io.src_instr[31:26];
    assign s_fn  = io.src_instr[5:0];

    always_comb begin
        ws_d = 5'd0;
        we_d = 1'b0;
        if (d_opc == OPC_RTYPE) begin
            ws_d = io.dest_instr[15:11];
            we_d = (d_fn != FN_JR);
        end else if ((d_opc >= OPC_ADDI && d_opc <= OPC_LUI)
                     || d_opc == OPC_LW) begin
            ws_d = io.dest_instr[20:16];
            we_d = 1'b1;
        end else if (d_opc == OPC_JAL) begin
            ws_d = REG_RA;
            we_d = 1'b1;
        end
        // $zero is never a hazard source
        if (ws_d == 5'd0)
            we_d = 1'b0;
    end

    always_comb begin
        re1_d = 1'b0;
        if (s_opc == OPC_RTYPE)
            re1_d = !(s_fn == FN_SLL || s_fn == FN_SRL || s_fn == FN_SRA);
        else if (s_opc == OPC_BEQ || s_opc == OPC_BNE
                 || (s_opc >= OPC_ADDI && s_opc <= OPC_XORI)
                 || s_opc == OPC_LW || s_opc == OPC_SW)
            re1_d = 1'b1;
        if (io.src_instr[25:21] == 5'd0)
            re1_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= 32'd0;
            zero_q   <= 1'b0;
            lt_q     <= 1'b0;
            gt_q     <= 1'b0;
            bcond_q  <= 1'b0;
            ws_q     <= 5'd0;
            we_q     <= 1'b0;
            re1_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            lt_q     <= lt_d;
            gt_q     <= gt_d;
            bcond_q  <= bcond_d;
            ws_q     <= ws_d;
            we_q     <= we_d;
            re1_q    <= re1_d;
        end
    end

    assign io.result = result_q;
    assign io.zero   = zero_q;
    assign io.lt     = lt_q;
    assign io.gt     = gt_q;
    assign io.bcond  = bcond_q;
    assign io.ws     = ws_q;
    assign io.we     = we_q;
    assign io.re1    = re1_q;

endmodule

// File: tb/tb_alu_cdest_cre.sv
// Directed bench for alu_cdest_cre: scoreboard of expected output
// sets, checked one edge after each input set is driven.
module tb_alu_cdest_cre;

    typedef struct packed {
        logic [31:0] r;
        logic        z;
        logic        lt;
        logic        gt;
        logic        bc;
        logic [4:0]  ws;
        logic        we;
        logic        re1;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t prev;
    exp_t zero_e;

    alu_cdest_cre_if bus ();

    alu_cdest_cre dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] r, input logic z,
                                input logic lt, input logic gt,
                                input logic bc, input logic [4:0] ws,
                                input logic we, input logic re1);
        exp_t e;
        e.r = r; e.z = z; e.lt = lt; e.gt = gt; e.bc = bc;
        e.ws = ws; e.we = we; e.re1 = re1;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".result"}, bus.result, e.r);
        chk({tag, ".zero"}, 32'(bus.zero), 32'(e.z));
        chk({tag, ".lt"}, 32'(bus.lt), 32'(e.lt));
        chk({tag, ".gt"}, 32'(bus.gt), 32'(e.gt));
        chk({tag, ".bcond"}, 32'(bus.bcond), 32'(e.bc));
        chk({tag, ".ws"}, 32'(bus.ws), 32'(e.ws));
        chk({tag, ".we"}, 32'(bus.we), 32'(e.we));
        chk({tag, ".re1"}, 32'(bus.re1), 32'(e.re1));
    endtask

    // Called 1 time unit after a rising edge
    task automatic step(input string tag, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] op,
                        input logic [31:0] di, input logic [31:0] si,
                        input exp_t e);
        exp_t got;
        bus.a = a; bus.b = b; bus.alu_op = op;
        bus.dest_instr = di; bus.src_instr = si;
        sb.push_back(e);
        #3;
        chk_all({tag, ".hold"}, prev);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk_all(tag, got);
        prev = got;
    endtask

    initial begin
        zero_e = mk(32'd0, 0, 0, 0, 0, 5'd0, 0, 0);
        bus.a = 32'hDEAD_BEEF; bus.b = 32'h1234_5678; bus.alu_op = 4'd1;
        bus.dest_instr = 32'h0022_1820; bus.src_instr = 32'h20C5_0001;
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_all("rst_async", zero_e);
        @(posedge clk);
        #1;
        chk_all("rst_hold", zero_e);
        rst = 1'b0;
        prev = zero_e;

        step("add", 32'd5, 32'd7, 4'd0, 32'h0022_1820, 32'h20C5_0001,
             mk(32'd12, 0, 1, 0, 0, 5'd3, 1, 1));
        step("sub", 32'd5, 32'd7, 4'd1, 32'h8C89_0000, 32'h3C05_0007,
             mk(32'hFFFF_FFFE, 0, 1, 0, 0, 5'd9, 1, 0));
        step("slt", 32'h8000_0000, 32'd1, 4'd6, 32'h0C00_0010, 32'h0003_1100,
             mk(32'd1, 0, 1, 0, 0, 5'd31, 1, 0));
        step("sltu", 32'h8000_0000, 32'd1, 4'd7, 32'hACC5_0000, 32'h0002_0820,
             mk(32'd0, 1, 1, 0, 0, 5'd0, 0, 0));
        step("sra", 32'd4, 32'h8000_0000, 4'd10, 32'h1022_0004, 32'h03E0_0008,
             mk(32'hF800_0000, 0, 0, 1, 0, 5'd0, 0, 1));
        step("eq_t", 32'h1234, 32'h1234, 4'd12, 32'h03E0_0008, 32'hACC5_0000,
             mk(32'd0, 1, 0, 0, 1, 5'd0, 0, 1));
        step("ne_f", 32'h1234, 32'h1234, 4'd13, 32'd32, 32'h1022_0004,
             mk(32'd0, 1, 0, 0, 0, 5'd0, 0, 1));
        step("add_nb", 32'h1234, 32'h1234, 4'd0, 32'h20C5_0001, 32'd32,
             mk(32'h2468, 0, 0, 0, 0, 5'd5, 1, 0));
        step("and", 32'hF0F0_00FF, 32'h0FF0_0F0F, 4'd2, 32'h3C05_0007,
             32'h0800_0000, mk(32'h00F0_000F, 0, 1, 0, 0, 5'd5, 1, 0));
        step("or", 32'hF0F0_00FF, 32'h0FF0_0F0F, 4'd3, 32'h0800_0000,
             32'h0023_1100, mk(32'hFFF0_0FFF, 0, 1, 0, 0, 5'd0, 0, 0));
        step("xor", 32'hF0F0_00FF, 32'h0FF0_0F0F, 4'd4, 32'h0002_0820,
             32'h8C89_0000, mk(32'hFF00_0FF0, 0, 1, 0, 0, 5'd1, 1, 1));
        step("nor", 32'hF0F0_00FF, 32'h0FF0_0F0F, 4'd5, 32'd32, 32'd32,
             mk(32'h000F_F000, 0, 1, 0, 0, 5'd0, 0, 0));
        step("sll", 32'd4, 32'h8000_0001, 4'd8, 32'd0, 32'd0,
             mk(32'h0000_0010, 0, 0, 1, 0, 5'd0, 0, 0));
        step("srl", 32'd4, 32'h8000_0001, 4'd9, 32'hFC22_1820, 32'hFC22_1820,
             mk(32'h0800_0000, 0, 0, 1, 0, 5'd0, 0, 0));
        step("lui", 32'd4, 32'h1234_ABCD, 4'd11, 32'h38C5_0001, 32'h38C5_0001,
             mk(32'hABCD_0000, 0, 1, 0, 0, 5'd5, 1, 1));
        step("passb", 32'h11, 32'h22, 4'd14, 32'h2020_0001, 32'd32,
             mk(32'h22, 0, 1, 0, 0, 5'd0, 0, 0));
        step("passa", 32'h11, 32'h22, 4'd15, 32'd32, 32'd32,
             mk(32'h11, 0, 1, 0, 0, 5'd0, 0, 0));
        step("ne_t", 32'd3, 32'd1, 4'd13, 32'd32, 32'd32,
             mk(32'd2, 0, 0, 1, 1, 5'd0, 0, 0));
        step("eq_f", 32'd3, 32'd1, 4'd12, 32'd32, 32'd32,
             mk(32'd2, 0, 0, 1, 0, 5'd0, 0, 0));
        step("slt0", 32'd1, 32'h8000_0000, 4'd6, 32'd32, 32'd32,
             mk(32'd0, 1, 0, 1, 0, 5'd0, 0, 0));
        step("sltu1", 32'd1, 32'h8000_0000, 4'd7, 32'd32, 32'd32,
             mk(32'd1, 0, 0, 1, 0, 5'd0, 0, 0));
        step("sra_msk", 32'h24, 32'h8000_0000, 4'd10, 32'd32, 32'd32,
             mk(32'hF800_0000, 0, 0, 1, 0, 5'd0, 0, 0));

        #2;
        rst = 1'b1;
        #1;
        chk_all("rst_mid", zero_e);
        @(posedge clk);
        #1;
        chk_all("rst_mid_hold", zero_e);
        rst = 1'b0;
        prev = zero_e;
        step("post_rst", 32'd5, 32'd7, 4'd0, 32'h0022_1820, 32'h20C5_0001,
             mk(32'd12, 0, 1, 0, 0, 5'd3, 1, 1));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
